// File: rtl/seg_scan_controller.sv
// Multiplexed scan controller for a common-anode 7-segment display bank.
// One shared hex decoder; digit values are latched only at digit boundaries.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              dec_nibble,
    input  logic [6:0]              dec_seg,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ?
                          REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] SHOW_PEN   = CW'(REFRESH_DIV - 2);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [IW-1:0]           idx, idx_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow, active, active_d;
    logic [3:0]              nib_d;
    logic [6:0]              seg_d;
    logic [NUM_DIGITS-1:0]   an_d, an_sel;
    logic                    fd_d;
    logic                    blank_done, show_done, blank_entry;

    assign blank_done  = (cnt == BLANK_LAST);
    assign show_done   = (cnt == SHOW_LAST);
    assign blank_entry = (state_d == BLANK) && (state != BLANK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            active     <= '0;
            dec_nibble <= 4'h0;
            seg_n      <= 7'h7F;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            active     <= active_d;
            dec_nibble <= nib_d;
            seg_n      <= seg_d;
            an_n       <= an_d;
            frame_done <= fd_d;
            if (load) begin
                shadow <= value;
            end
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt + CW'(1);
        unique case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (enable) state_d = BLANK;
            end
            BLANK: begin
                if (blank_done) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (show_done) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    // Anode pattern for the current digit; a masked digit stays dark.
    always_comb begin
        an_sel = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k) && !blank_mask[k]) an_sel[k] = 1'b0;
        end
    end

    always_comb begin
        active_d = active;
        nib_d    = dec_nibble;
        seg_d    = seg_n;
        an_d     = '1;
        fd_d     = 1'b0;
        // The value is snapshotted from the pre-edge shadow at BLANK entry.
        if (blank_entry) begin
            active_d = shadow;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_d == IW'(k)) nib_d = shadow[4*k +: 4];
            end
        end
        unique case (state)
            IDLE: seg_d = 7'h7F;
            BLANK: begin
                seg_d = ~dec_seg;
                if (blank_done) an_d = an_sel;
            end
            SHOW: begin
                if (!show_done) an_d = an_sel;
                fd_d = (cnt == SHOW_PEN) && (idx == IDX_LAST);
            end
            default: seg_d = 7'h7F;
        endcase
        if (!enable) begin
            seg_d = 7'h7F;
            an_d  = '1;
            fd_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed test-plan steps plus random
// stimulus, checked against a time-position model of the scan.
module tb_seg_scan_controller;

    localparam int N = 4;
    localparam int R = 8;
    localparam int B = 2;
    localparam int D = B + R;

    logic          clk = 1'b0;
    logic          reset, enable, load;
    logic [15:0]   value;
    logic [3:0]    blank_mask;
    logic [3:0]    dec_nibble;
    logic [6:0]    dec_seg;
    logic [6:0]    seg_n;
    logic [3:0]    an_n;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    bit          running = 0;
    int          t = 0, pos = 0, dig = 0;
    logic [15:0] m_shadow = '0, m_latched = '0;
    logic [6:0]  m_seg = 7'h7F;
    logic [3:0]  m_dn = 4'h0;

    always #5 clk = ~clk;

    seg_scan_controller #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .value(value), .blank_mask(blank_mask),
        .dec_nibble(dec_nibble), .dec_seg(dec_seg),
        .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
    );

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    always_comb dec_seg = hexseg(dec_nibble);

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l,
                        input logic [15:0] v, input logic [3:0] m);
        logic [3:0] exp_an;
        logic       exp_fd;
        reset = r; enable = e; load = l; value = v; blank_mask = m;
        @(posedge clk);
        if (r) begin
            running  = 0;
            m_shadow = '0;
            m_seg    = 7'h7F;
            m_dn     = 4'h0;
        end else begin
            if (!running) begin
                if (e) begin
                    running   = 1;
                    t         = 0;
                    m_latched = m_shadow;
                end
            end else if (!e) begin
                running = 0;
            end else begin
                t++;
                if (t % D == 0) m_latched = m_shadow;
            end
            if (l) m_shadow = v;
            if (!running) begin
                m_seg = 7'h7F;
            end else begin
                pos  = t % D;
                dig  = (t / D) % N;
                m_dn = 4'(m_latched >> (4 * dig));
                if (pos != 0) m_seg = ~hexseg(m_dn);
            end
        end
        exp_an = 4'hF;
        exp_fd = 1'b0;
        if (running) begin
            if (pos >= B && !m[dig]) exp_an[dig] = 1'b0;
            exp_fd = (pos == D - 1) && (dig == N - 1);
        end
        #1;
        check("an_n", 16'(an_n), 16'(exp_an));
        check("seg_n", 16'(seg_n), 16'(m_seg));
        check("frame_done", 16'(frame_done), 16'(exp_fd));
        check("dec_nibble", 16'(dec_nibble), 16'(m_dn));
    endtask

    initial begin
        bit         en_r;
        bit         found;
        logic [3:0] mask_r;
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        value = '0; blank_mask = '0;

        // reset with enable high, then 3-cycle latency to first anode
        repeat (3) step(1, 1, 0, 16'h0, 4'h0);
        check("rst_an", 16'(an_n), 16'hF);
        check("rst_seg", 16'(seg_n), 16'h7F);
        step(0, 1, 0, 16'h0, 4'h0);
        check("lat1_an", 16'(an_n), 16'hF);
        step(0, 1, 0, 16'h0, 4'h0);
        check("lat2_an", 16'(an_n), 16'hF);
        step(0, 1, 0, 16'h0, 4'h0);
        check("lat3_an", 16'(an_n), 16'hE);
        check("lat3_seg", 16'(seg_n), 16'h40);

        // scan order with 1234
        step(0, 0, 1, 16'h1234, 4'h0);
        repeat (3) step(0, 1, 0, 16'h0, 4'h0);
        check("d0_an", 16'(an_n), 16'hE);
        check("d0_seg", 16'(seg_n), 16'h19);
        repeat (10) step(0, 1, 0, 16'h0, 4'h0);
        check("d1_an", 16'(an_n), 16'hD);
        check("d1_seg", 16'(seg_n), 16'h30);

        // load mid-SHOW of digit 1 must not tear it
        step(0, 1, 1, 16'h8888, 4'h0);
        repeat (6) step(0, 1, 0, 16'h0, 4'h0);
        check("tear_d1_an", 16'(an_n), 16'hD);
        check("tear_d1_seg", 16'(seg_n), 16'h30);
        repeat (3) step(0, 1, 0, 16'h0, 4'h0);
        check("tear_d2_an", 16'(an_n), 16'hB);
        check("tear_d2_seg", 16'(seg_n), 16'h00);
        repeat (40) step(0, 1, 0, 16'h0, 4'h0);

        // blank mask on digit 3
        step(0, 1, 1, 16'h0A5F, 4'b1000);
        for (int i = 0; i < 100; i++) begin
            step(0, 1, 0, 16'h0, 4'b1000);
            check("mask3", 16'(an_n[3]), 16'h1);
        end

        // enable drop mid-SHOW of digit 2
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step(0, 1, 0, 16'h0, 4'h0);
            found = running && dig == 2 && pos == 5;
        end
        check("find_d2", 16'(found), 16'h1);
        step(0, 0, 0, 16'h0, 4'h0);
        check("drop_an", 16'(an_n), 16'hF);
        check("drop_seg", 16'(seg_n), 16'h7F);
        repeat (3) step(0, 1, 0, 16'h0, 4'h0);
        check("restart_an", 16'(an_n), 16'hE);

        // reset mid-BLANK after 1.5 frames
        repeat (57) step(0, 1, 0, 16'h0, 4'h0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(0, 1, 0, 16'h0, 4'h0);
            found = running && pos == 0;
        end
        check("find_blank", 16'(found), 16'h1);
        step(1, 1, 0, 16'h0, 4'h0);
        check("mrst_an", 16'(an_n), 16'hF);
        check("mrst_seg", 16'(seg_n), 16'h7F);
        check("mrst_dn", 16'(dec_nibble), 16'h0);
        repeat (3) step(0, 1, 0, 16'h0, 4'h0);
        check("mrst_d0_seg", 16'(seg_n), 16'h40);
        check("mrst_d0_an", 16'(an_n), 16'hE);

        // random traffic
        en_r   = 1;
        mask_r = 4'h0;
        for (int i = 0; i < 4000; i++) begin
            if (en_r) en_r = ($urandom_range(299) != 0);
            else      en_r = ($urandom_range(7) == 0);
            if ($urandom_range(59) == 0) mask_r = 4'($urandom);
            step($urandom_range(699) == 0, en_r,
                 $urandom_range(11) == 0, 16'($urandom), mask_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
